// File: rtl/stopwatch_ctrl_if.sv
// Command, digit read-back and counter-control bundle between the stopwatch
// controller and its two external decade counters.
interface stopwatch_ctrl_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic       preset_valid;
  logic [3:0] preset_tens;
  logic [3:0] preset_units;
  logic [3:0] units_q;
  logic [3:0] tens_q;
  logic       units_en;
  logic       tens_en;
  logic       cnt_load;
  logic [3:0] units_din;
  logic [3:0] tens_din;
  logic [1:0] state;
  logic       done;
  logic       preset_err;

  modport master (
    output start, stop, clear, preset_valid, preset_tens, preset_units,
    output units_q, tens_q,
    input  units_en, tens_en, cnt_load, units_din, tens_din,
    input  state, done, preset_err
  );

  modport slave (
    input  start, stop, clear, preset_valid, preset_tens, preset_units,
    input  units_q, tens_q,
    output units_en, tens_en, cnt_load, units_din, tens_din,
    output state, done, preset_err
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Two-digit BCD stopwatch controller: sequences start/stop/clear/preset commands
// and paces an external pair of decade counters with a programmable prescaler.
module stopwatch_ctrl #(
  parameter int PRESCALE  = 4,
  parameter int AUTO_STOP = 0
) (
  input  logic            clock,
  input  logic            reset_n,
  stopwatch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LOAD  = 2'b11
  } state_t;

  localparam logic [7:0] PRESC_MAX = 8'(PRESCALE - 1);

  state_t     r_state, w_state_nxt;
  logic [7:0] r_presc, w_presc_nxt;
  logic [3:0] r_load_u, w_load_u_nxt;
  logic [3:0] r_load_t, w_load_t_nxt;
  logic       r_done, w_done_nxt;
  logic       r_perr, w_perr_nxt;
  logic       w_tick;
  logic       w_rollover;
  logic [3:0] w_sat_u, w_sat_t;
  logic       w_bad_preset;

  // Out-of-range BCD digits are clamped as they are captured.
  assign w_sat_u      = (bus.preset_units > 4'd9) ? 4'd9 : bus.preset_units;
  assign w_sat_t      = (bus.preset_tens  > 4'd9) ? 4'd9 : bus.preset_tens;
  assign w_bad_preset = (bus.preset_units > 4'd9) || (bus.preset_tens > 4'd9);

  assign w_rollover = w_tick && (bus.units_q == 4'd9) && (bus.tens_q == 4'd9);

  always_comb begin
    w_state_nxt  = r_state;
    w_presc_nxt  = r_presc;
    w_load_u_nxt = r_load_u;
    w_load_t_nxt = r_load_t;
    w_done_nxt   = 1'b0;
    w_perr_nxt   = 1'b0;
    w_tick       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.clear) begin
          w_state_nxt  = LOAD;
          w_load_u_nxt = 4'd0;
          w_load_t_nxt = 4'd0;
        end else if (!bus.stop) begin
          if (bus.start) begin
            w_state_nxt = RUN;
            w_presc_nxt = 8'd0;
          end else if (bus.preset_valid) begin
            w_state_nxt  = LOAD;
            w_load_u_nxt = w_sat_u;
            w_load_t_nxt = w_sat_t;
            w_perr_nxt   = w_bad_preset;
          end
        end
      end
      RUN: begin
        if (bus.clear) begin
          w_state_nxt  = LOAD;
          w_load_u_nxt = 4'd0;
          w_load_t_nxt = 4'd0;
          w_presc_nxt  = 8'd0;
        end else if (bus.stop) begin
          // Prescaler phase is held so a resume continues mid-period.
          w_state_nxt = PAUSE;
        end else begin
          w_tick      = (r_presc == PRESC_MAX);
          w_presc_nxt = w_tick ? 8'd0 : r_presc + 8'd1;
          w_done_nxt  = w_rollover;
          if (w_rollover && (AUTO_STOP != 0)) w_state_nxt = IDLE;
        end
      end
      PAUSE: begin
        if (bus.clear) begin
          w_state_nxt  = LOAD;
          w_load_u_nxt = 4'd0;
          w_load_t_nxt = 4'd0;
          w_presc_nxt  = 8'd0;
        end else if (!bus.stop && bus.start) begin
          w_state_nxt = RUN;
        end
      end
      LOAD: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_presc  <= 8'd0;
      r_load_u <= 4'd0;
      r_load_t <= 4'd0;
      r_done   <= 1'b0;
      r_perr   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_presc  <= w_presc_nxt;
      r_load_u <= w_load_u_nxt;
      r_load_t <= w_load_t_nxt;
      r_done   <= w_done_nxt;
      r_perr   <= w_perr_nxt;
    end
  end

  // Enables only exist in RUN, so they can never coincide with cnt_load.
  assign bus.units_en   = w_tick;
  assign bus.tens_en    = w_tick && (bus.units_q == 4'd9);
  assign bus.cnt_load   = (r_state == LOAD);
  assign bus.units_din  = r_load_u;
  assign bus.tens_din   = r_load_t;
  assign bus.state      = r_state;
  assign bus.done       = r_done;
  assign bus.preset_err = r_perr;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: two instances (PRESCALE=4/free-running and
// PRESCALE=1/auto-stop) driving real decade counters, checked every cycle.
module tb_stopwatch_ctrl;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start, stop, clear, pv;
  logic [3:0] pt, pu;
  logic [3:0] u0, t0, u1, t1;

  always #5 clock = ~clock;

  stopwatch_ctrl_if sw0 ();
  stopwatch_ctrl_if sw1 ();

  stopwatch_ctrl #(.PRESCALE(4), .AUTO_STOP(0)) dut_a (
    .clock(clock), .reset_n(reset_n), .bus(sw0.slave));
  stopwatch_ctrl #(.PRESCALE(1), .AUTO_STOP(1)) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(sw1.slave));

  assign sw0.start = start;  assign sw0.stop = stop;  assign sw0.clear = clear;
  assign sw0.preset_valid = pv; assign sw0.preset_tens = pt; assign sw0.preset_units = pu;
  assign sw0.units_q = u0;   assign sw0.tens_q = t0;
  assign sw1.start = start;  assign sw1.stop = stop;  assign sw1.clear = clear;
  assign sw1.preset_valid = pv; assign sw1.preset_tens = pt; assign sw1.preset_units = pu;
  assign sw1.units_q = u1;   assign sw1.tens_q = t1;

  // External decade counters, one digit pair per instance.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      u0 <= 4'd0; t0 <= 4'd0;
    end else if (sw0.cnt_load) begin
      u0 <= sw0.units_din; t0 <= sw0.tens_din;
    end else begin
      if (sw0.units_en) u0 <= (u0 == 4'd9) ? 4'd0 : u0 + 4'd1;
      if (sw0.tens_en)  t0 <= (t0 == 4'd9) ? 4'd0 : t0 + 4'd1;
    end
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      u1 <= 4'd0; t1 <= 4'd0;
    end else if (sw1.cnt_load) begin
      u1 <= sw1.units_din; t1 <= sw1.tens_din;
    end else begin
      if (sw1.units_en) u1 <= (u1 == 4'd9) ? 4'd0 : u1 + 4'd1;
      if (sw1.tens_en)  t1 <= (t1 == 4'd9) ? 4'd0 : t1 + 4'd1;
    end
  end

  typedef struct {
    int mode;   // 0 idle, 1 run, 2 pause, 3 load
    int phase;  // cycles into the current count period
    int lu;
    int lt;
    int val;    // displayed value 0..99
    bit done_q;
    bit perr_q;
  } mdl_t;

  typedef struct {
    logic [1:0] state;
    logic       ue, te, ld;
    logic [3:0] du, dt;
    logic       dn, pe;
    logic [3:0] uq, tq;
  } obs_t;

  mdl_t md[2];
  int   PSC[2] = '{4, 1};
  int   AST[2] = '{0, 1};

  int n_chk = 0, n_pass = 0, cyc = 0;
  int n_ue[2], n_te[2], n_done[2], n_load[2], n_perr[2], last_du[2], last_dt[2];
  int run_cnt, first_tick;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) md[k] = '{default: 0};
  endtask

  task automatic tally_clear();
    for (int k = 0; k < 2; k++) begin
      n_ue[k] = 0; n_te[k] = 0; n_done[k] = 0; n_load[k] = 0; n_perr[k] = 0;
      last_du[k] = -1; last_dt[k] = -1;
    end
    run_cnt = 0; first_tick = -1;
  endtask

  // Compare one instance against the model, then advance the model one clock.
  task automatic step(input int k, input obs_t o);
    string id;
    bit    tick, roll;
    id   = $sformatf("%s@%0d", (k == 0) ? "A" : "B", cyc);
    tick = (md[k].mode == 1) && !clear && !stop && (md[k].phase == PSC[k] - 1);
    roll = tick && (md[k].val == 99);
    chk({id, ".state"},      int'(o.state), md[k].mode);
    chk({id, ".units_en"},   int'(o.ue), int'(tick));
    chk({id, ".tens_en"},    int'(o.te), int'(tick && (md[k].val % 10 == 9)));
    chk({id, ".cnt_load"},   int'(o.ld), int'(md[k].mode == 3));
    if (md[k].mode == 3) begin
      chk({id, ".units_din"}, int'(o.du), md[k].lu);
      chk({id, ".tens_din"},  int'(o.dt), md[k].lt);
    end
    chk({id, ".done"},       int'(o.dn), int'(md[k].done_q));
    chk({id, ".preset_err"}, int'(o.pe), int'(md[k].perr_q));
    chk({id, ".units_q"},    int'(o.uq), md[k].val % 10);
    chk({id, ".tens_q"},     int'(o.tq), md[k].val / 10);

    if (md[k].mode == 3)  md[k].val = md[k].lt * 10 + md[k].lu;
    else if (tick)        md[k].val = (md[k].val + 1) % 100;
    md[k].done_q = roll;
    md[k].perr_q = 1'b0;
    case (md[k].mode)
      0: if (clear) begin
           md[k].mode = 3; md[k].lu = 0; md[k].lt = 0;
         end else if (!stop) begin
           if (start) begin
             md[k].mode = 1; md[k].phase = 0;
           end else if (pv) begin
             md[k].mode = 3;
             md[k].lu = (pu > 9) ? 9 : int'(pu);
             md[k].lt = (pt > 9) ? 9 : int'(pt);
             md[k].perr_q = (pu > 9) || (pt > 9);
           end
         end
      1: if (clear) begin
           md[k].mode = 3; md[k].lu = 0; md[k].lt = 0; md[k].phase = 0;
         end else if (stop) begin
           md[k].mode = 2;
         end else begin
           md[k].phase = (md[k].phase + 1) % PSC[k];
           if (roll && AST[k] != 0) md[k].mode = 0;
         end
      2: if (clear) begin
           md[k].mode = 3; md[k].lu = 0; md[k].lt = 0; md[k].phase = 0;
         end else if (!stop && start) begin
           md[k].mode = 1;
         end
      default: md[k].mode = 0;
    endcase

    if (o.ue) n_ue[k]++;
    if (o.te) n_te[k]++;
    if (o.dn) n_done[k]++;
    if (o.pe) n_perr[k]++;
    if (o.ld) begin n_load[k]++; last_du[k] = int'(o.du); last_dt[k] = int'(o.dt); end
    if (k == 0) begin
      if (o.state == 2'd1) run_cnt++;
      if (o.ue && first_tick < 0) first_tick = run_cnt;
    end
  endtask

  task automatic run(input int n);
    obs_t o;
    repeat (n) begin
      @(negedge clock);
      o = '{sw0.state, sw0.units_en, sw0.tens_en, sw0.cnt_load, sw0.units_din,
            sw0.tens_din, sw0.done, sw0.preset_err, sw0.units_q, sw0.tens_q};
      step(0, o);
      o = '{sw1.state, sw1.units_en, sw1.tens_en, sw1.cnt_load, sw1.units_din,
            sw1.tens_din, sw1.done, sw1.preset_err, sw1.units_q, sw1.tens_q};
      step(1, o);
      cyc++;
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive(input logic c, input logic s, input logic st, input logic v,
                       input logic [3:0] t, input logic [3:0] u);
    clear = c; stop = s; start = st; pv = v; pt = t; pu = u;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".state"},      int'(sw0.state), 0);
    chk({tag, ".units_en"},   int'(sw0.units_en), 0);
    chk({tag, ".tens_en"},    int'(sw0.tens_en), 0);
    chk({tag, ".cnt_load"},   int'(sw0.cnt_load), 0);
    chk({tag, ".done"},       int'(sw0.done), 0);
    chk({tag, ".preset_err"}, int'(sw0.preset_err), 0);
    chk({tag, ".units_din"},  int'(sw0.units_din), 0);
    chk({tag, ".tens_din"},   int'(sw0.tens_din), 0);
    chk({tag, ".B.state"},    int'(sw1.state), 0);
  endtask

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 4'd0, 4'd0);
    model_reset();
    tally_clear();
    repeat (2) @(posedge clock);
    #1;
    chk_reset_outputs("reset");
    reset_n = 1'b1;

    // Clear, start, first tick on the 4th RUN cycle, then ten ticks to 10.
    drive(1, 0, 0, 0, 4'd0, 4'd0); run(1);
    drive(0, 0, 0, 0, 4'd0, 4'd0); run(1);
    tally_clear();
    drive(0, 0, 1, 0, 4'd0, 4'd0); run(1);
    drive(0, 0, 0, 0, 4'd0, 4'd0); run(4);
    chk("s1.first_tick_run_cycle", first_tick, 4);
    chk("s1.units_after_1", int'(u0), 1);
    run(36);
    chk("s1.units_after_10", int'(u0), 0);
    chk("s1.tens_after_10", int'(t0), 1);
    chk("s1.tens_en_count", n_te[0], 1);
    chk("s1.units_en_count", n_ue[0], 10);

    // Stop on a tick cycle, idle in PAUSE, resume at the held phase.
    drive(0, 1, 0, 0, 4'd0, 4'd0); run(1);
    drive(1, 0, 0, 0, 4'd0, 4'd0); run(1);
    drive(0, 0, 0, 0, 4'd0, 4'd0); run(1);
    drive(0, 0, 1, 0, 4'd0, 4'd0); run(1);
    drive(0, 0, 0, 0, 4'd0, 4'd0); run(3);
    tally_clear();
    drive(0, 1, 0, 0, 4'd0, 4'd0); run(1);
    chk("s2.no_tick_on_stop", n_ue[0], 0);
    chk("s2.state_pause", int'(sw0.state), 2);
    drive(0, 0, 0, 0, 4'd0, 4'd0); run(5);
    drive(0, 0, 1, 0, 4'd0, 4'd0); run(1);
    tally_clear();
    drive(0, 0, 0, 0, 4'd0, 4'd0); run(1);
    chk("s2.resume_tick_immediate", n_ue[0], 1);
    chk("s2.units_after_resume", int'(u0), 1);

    // Out-of-range preset is clamped and flagged.
    drive(0, 1, 0, 0, 4'd0, 4'd0); run(1);
    drive(1, 0, 0, 0, 4'd0, 4'd0); run(1);
    drive(0, 0, 0, 0, 4'd0, 4'd0); run(1);
    tally_clear();
    drive(0, 0, 0, 1, 4'd12, 4'd3); run(1);
    drive(0, 0, 0, 0, 4'd0, 4'd0); run(2);
    chk("s3.cnt_load_cycles", n_load[0], 1);
    chk("s3.preset_err_pulses", n_perr[0], 1);
    chk("s3.tens_din", last_dt[0], 9);
    chk("s3.units_din", last_du[0], 3);
    chk("s3.tens_q", int'(t0), 9);
    chk("s3.units_q", int'(u0), 3);

    // Preset 98, two ticks roll over through 99 to 00.
    drive(0, 0, 0, 1, 4'd9, 4'd8); run(1);
    drive(0, 0, 0, 0, 4'd0, 4'd0); run(1);
    drive(0, 0, 1, 0, 4'd0, 4'd0); run(1);
    tally_clear();
    drive(0, 0, 0, 0, 4'd0, 4'd0); run(4);
    chk("s4.A_at_99", int'(t0) * 10 + int'(u0), 99);
    run(5);
    chk("s4.A_at_00", int'(t0) * 10 + int'(u0), 0);
    chk("s4.A_done_count", n_done[0], 1);
    chk("s4.A_still_run", int'(sw0.state), 1);
    chk("s4.B_done_count", n_done[1], 1);
    chk("s4.B_idle_after_roll", int'(sw1.state), 0);
    chk("s4.B_at_00", int'(t1) * 10 + int'(u1), 0);

    // clear+stop+start together on a tick cycle.
    run(6);
    chk("s5.A_before_clear", int'(u0), 1);
    tally_clear();
    drive(1, 1, 1, 0, 4'd0, 4'd0); run(1);
    chk("s5.no_enable", n_ue[0], 0);
    chk("s5.state_load", int'(sw0.state), 3);
    drive(0, 0, 0, 0, 4'd0, 4'd0); run(2);
    chk("s5.digits_00", int'(t0) * 10 + int'(u0), 0);

    // Asynchronous reset one cycle before a 99->00 rollover.
    drive(0, 0, 0, 1, 4'd9, 4'd9); run(1);
    drive(0, 0, 0, 0, 4'd0, 4'd0); run(1);
    drive(0, 0, 1, 0, 4'd0, 4'd0); run(1);
    drive(0, 0, 0, 0, 4'd0, 4'd0); run(3);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs("s6.async");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    tally_clear();
    run(5);
    chk("s6.no_done_after_release", n_done[0], 0);
    chk("s6.idle_after_release", int'(sw0.state), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
